// File: rtl/core_control_exception_prio_pkg.sv
// Exception arbitration shared types: cause encoding,
// vector offsets and ARM mode numbers.
package core_control_exception_prio_pkg;

  typedef enum logic [2:0] {
    EXC_NONE,
    DABT,
    FIQ,
    IRQ,
    PABT,
    UNDEF,
    SWI
  } exc_cause_e;

  localparam logic [4:0] OFF_DABT  = 5'h10;
  localparam logic [4:0] OFF_FIQ   = 5'h1C;
  localparam logic [4:0] OFF_IRQ   = 5'h18;
  localparam logic [4:0] OFF_PABT  = 5'h0C;
  localparam logic [4:0] OFF_UNDEF = 5'h04;
  localparam logic [4:0] OFF_SWI   = 5'h08;

  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SVC = 5'b10011;

  function automatic logic [4:0] exc_off(
    input exc_cause_e c
  );
    case (c)
      DABT:    exc_off = OFF_DABT;
      FIQ:     exc_off = OFF_FIQ;
      IRQ:     exc_off = OFF_IRQ;
      PABT:    exc_off = OFF_PABT;
      UNDEF:   exc_off = OFF_UNDEF;
      SWI:     exc_off = OFF_SWI;
      default: exc_off = 5'h00;
    endcase
  endfunction

  function automatic logic [4:0] exc_mode(
    input exc_cause_e c
  );
    case (c)
      DABT:    exc_mode = MODE_ABT;
      PABT:    exc_mode = MODE_ABT;
      FIQ:     exc_mode = MODE_FIQ;
      IRQ:     exc_mode = MODE_IRQ;
      UNDEF:   exc_mode = MODE_UND;
      default: exc_mode = MODE_SVC;
    endcase
  endfunction

endpackage

// File: rtl/core_control_exception_prio_if.sv
// Exception sources from decode/issue and the
// request/vector bundle returned to core control.
interface core_control_exception_prio_if #(
  parameter int NUM_IRQ = 4
);
  logic               issue_boundary;
  logic               issue;
  logic               escalate;
  logic               high_vectors;
  logic               mask_i;
  logic               mask_f;
  logic [NUM_IRQ-1:0] irq;
  logic               fiq;
  logic               undefined;
  logic               swi;
  logic               prefetch_abort;
  logic               data_abort;
  logic               exception;
  logic               escalating;
  logic [31:0]        exception_vector;
  logic [4:0]         exception_mode;
  logic               set_mask_f;
  logic [NUM_IRQ-1:0] irq_pending;

  modport master (
    output issue_boundary, issue, escalate,
    output high_vectors, mask_i, mask_f,
    output irq, fiq, undefined, swi,
    output prefetch_abort, data_abort,
    input  exception, escalating,
    input  exception_vector, exception_mode,
    input  set_mask_f, irq_pending
  );

  modport slave (
    input  issue_boundary, issue, escalate,
    input  high_vectors, mask_i, mask_f,
    input  irq, fiq, undefined, swi,
    input  prefetch_abort, data_abort,
    output exception, escalating,
    output exception_vector, exception_mode,
    output set_mask_f, irq_pending
  );
endinterface

// File: rtl/core_control_exception_prio_irqlatch.sv
// One IRQ line: rising-edge latch with clear-on-take,
// or pass-through when the line is level sensitive.
module core_control_exception_prio_irqlatch #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_irq,
  input  logic i_clr,
  output logic o_pend,
  output logic o_eff
);

  logic r_prev;
  logic r_pend;
  logic w_rise;

  assign w_rise = EDGE && i_irq && !r_prev;

  // a new edge wins over the clear of the taken one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= i_irq;
      if (w_rise)
        r_pend <= 1'b1;
      else if (i_clr)
        r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_eff  = EDGE ? r_pend : i_irq;

endmodule

// File: rtl/core_control_exception_prio.sv
// Fixed-priority ARM exception arbiter: latches the
// winning cause and holds the request until entry.
module core_control_exception_prio #(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE  = '0,
  parameter logic [31:0]        HIGH_BASE = 32'hFFFF0000
) (
  input logic clk,
  input logic rst_n,
  core_control_exception_prio_if.slave bus
);
  import core_control_exception_prio_pkg::*;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_ENTRY = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               r_pend_irq;
  logic               r_pend_fiq;
  exc_cause_e         r_cause;
  exc_cause_e         w_cause;
  logic [31:0]        r_vec;
  logic [4:0]         r_mode;
  logic [NUM_IRQ-1:0] r_frz;
  logic [NUM_IRQ-1:0] w_eff;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_irq_req;
  logic               w_fiq_req;
  logic               w_any;
  logic               w_take;
  logic               w_upd;
  logic [31:0]        w_base;

  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_irq
    core_control_exception_prio_irqlatch #(
      .EDGE(IRQ_EDGE[k])
    ) u_lat (
      .clk   (clk),
      .rst_n (rst_n),
      .i_irq (bus.irq[k]),
      .i_clr (w_clr[k]),
      .o_pend(w_pend[k]),
      .o_eff (w_eff[k])
    );
  end

  // sampled requests are re-qualified so a drop or mask cancels them
  assign w_irq_req = r_pend_irq && (|w_eff) && !bus.mask_i;
  assign w_fiq_req = r_pend_fiq && bus.fiq && !bus.mask_f;

  always_comb begin
    w_cause = EXC_NONE;
    if (bus.data_abort)
      w_cause = DABT;
    else if (w_fiq_req)
      w_cause = FIQ;
    else if (w_irq_req)
      w_cause = IRQ;
    else if (bus.prefetch_abort)
      w_cause = PABT;
    else if (bus.undefined)
      w_cause = UNDEF;
    else if (bus.swi)
      w_cause = SWI;
  end

  assign w_any  = (w_cause != EXC_NONE);
  assign w_take = (r_state == S_PEND) && w_any
                  && bus.escalate;
  assign w_upd  = (r_state != S_ENTRY) && w_any
                  && !w_take;
  assign w_base = bus.high_vectors ? HIGH_BASE : 32'h0;
  assign w_clr  = ((r_state == S_ENTRY) && (r_cause == IRQ))
                  ? r_frz : '0;

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_IDLE):
        if (w_any) w_next = S_PEND;
      (r_state == S_PEND):
        if (!w_any)            w_next = S_IDLE;
        else if (bus.escalate) w_next = S_ENTRY;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pend_irq <= 1'b0;
      r_pend_fiq <= 1'b0;
      r_cause    <= EXC_NONE;
      r_vec      <= 32'h0;
      r_mode     <= MODE_SVC;
      r_frz      <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_pend_irq <= 1'b0;
        r_pend_fiq <= 1'b0;
        r_frz      <= w_pend;
      end else if (bus.issue_boundary) begin
        r_pend_irq <= bus.issue && (|w_eff)
                      && !bus.mask_i;
        r_pend_fiq <= bus.issue && bus.fiq
                      && !bus.mask_f;
      end
      if (w_upd) begin
        r_cause <= w_cause;
        r_vec   <= w_base | {27'h0, exc_off(w_cause)};
        r_mode  <= exc_mode(w_cause);
      end
    end
  end

  assign bus.exception        = (r_state != S_ENTRY) && w_any;
  assign bus.escalating       = bus.escalate;
  assign bus.exception_vector = r_vec;
  assign bus.exception_mode   = r_mode;
  assign bus.set_mask_f       = (r_state == S_ENTRY)
                                && (r_cause == FIQ);
  assign bus.irq_pending      = w_pend;

endmodule

// File: doc/core_control_exception_prio.md
Name: core_control_exception_prio

Overview:
Parametrised successor to the core's exception control block. It arbitrates all ARM exception sources by fixed ARM priority: data abort, FIQ, IRQ (multi-line), prefetch abort, undefined and SWI. It latches the winning cause, drives the vector and target mode to core control, and holds the request until control acknowledges entry. It sits in core/control, between decode/issue and the escalation cycle of the control FSM.

Parameters:
NUM_IRQ, 4, number of external IRQ lines ORed into the IRQ cause (1..16)
IRQ_EDGE, 4'b0000, per-line mode bit: 1 = rising-edge latched, 0 = level
HIGH_BASE, 32'hFFFF0000, vector base used when high_vectors=1 (low base fixed 0)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
issue_boundary  in  1  next cycle is an issue cycle (sampling point for async sources)
issue  in  1  an instruction is issuing this cycle
escalate  in  1  control FSM is in the escalation cycle (exception entry)
high_vectors  in  1  select HIGH_BASE
mask_i  in  1  CPSR I bit
mask_f  in  1  CPSR F bit
irq  in  NUM_IRQ  external IRQ lines
fiq  in  1  external FIQ (level)
undefined  in  1  decode flagged undefined insn
swi  in  1  decode flagged SWI
prefetch_abort  in  1  fetch fault for issuing insn
data_abort  in  1  memory fault, any cycle
exception  out  1  request to control: take exception
escalating  out  1  mirrors escalate
exception_vector  out  32  base + offset of latched cause
exception_mode  out  5  ARM mode: 10111 abort, 10001 FIQ, 10010 IRQ, 11011 undef, 10011 SVC
set_mask_f  out  1  entering FIQ (control sets F and I)
irq_pending  out  NUM_IRQ  edge-latch state, for debug/status

Behaviour:
- Reset: exception=0, exception_vector=0, exception_mode=10011, set_mask_f=0, irq_pending=0, FSM=IDLE.
- Async sampling: at posedge, if issue_boundary, pend_irq <= issue && |eff_irq && !mask_i and pend_fiq <= issue && fiq && !mask_f. eff_irq[k] = IRQ_EDGE[k] ? irq_pending[k] : irq[k].
- Edge latch: irq_pending[k] sets on 0->1 of irq[k] (previous-value register). It clears only on IRQ entry (below). Set has priority over clear in the same cycle.
- Sync sources (data_abort, prefetch_abort, undefined, swi) are combinational requests, valid the cycle they are asserted.
- Priority: dabt > fiq > irq > pabt > undef > swi. Offsets: 0x10, 0x1C, 0x18, 0x0C, 0x04, 0x08. Vector = (high_vectors ? HIGH_BASE : 0) | offset.
- FSM IDLE: any request -> PENDING; exception=1 combinationally the same cycle; vector/mode registered at that edge.
- FSM PENDING: exception=1. Vector/mode recompute every cycle, so a higher-priority arrival overrides. On escalate the cause is frozen -> ENTRY.
- FSM ENTRY: exception=0 for exactly one cycle (no re-trigger) -> IDLE.
  - If the cause was IRQ, clear every irq_pending bit that was set at the freeze.
  - If the cause was FIQ, set_mask_f=1 for that cycle.
  - pend_irq/pend_fiq clear on entry to ENTRY.
- A request that disappears while PENDING, before escalate (level IRQ drops, mask set), drops it; the FSM returns to IDLE if no request remains.
- Reset mid-PENDING/ENTRY: immediate return to reset values; edge latches lost.
- escalating = escalate, unregistered.

Decomposition:
- Shared uarch package gets: exception cause enum (EXC_NONE, DABT, FIQ, IRQ, PABT, UNDEF, SWI), vector offset constants, ARM mode constants.
- Sub-module core_control_exception_irqlatch: per-line edge/level latch with clear-on-take, generated over NUM_IRQ.

Test Plan:
- Reset, then undefined=1 in IDLE, low vectors -> exception=1 same cycle; next cycle vector=0x00000004, mode=11011; escalate -> exception=0 one cycle, then IDLE.
- irq[2]=1 (level), mask_i=0, issue and issue_boundary=1 -> one cycle later exception=1, vector=0x00000018, mode=10010; with mask_i=1, no exception.
- FIQ and IRQ together, high_vectors=1 -> vector=0xFFFF001C, set_mask_f=1 in ENTRY cycle.
- IRQ PENDING, then data_abort=1 before escalate -> vector switches to 0x10, mode 10111; after entry IRQ still pending re-triggers.
- IRQ_EDGE[0]=1, 1-cycle pulse on irq[0] -> irq_pending[0]=1 held; IRQ taken -> cleared in ENTRY; new edge in ENTRY cycle keeps bit set.
- rst_n low during PENDING -> all outputs to reset values asynchronously, irq_pending=0.
